imm_extend_pipe: RTL and testbench
==================================

Name: imm_extend_pipe

Overview:
- Parametrised successor to the fixed 20-to-32 extender: a pipelined immediate generator for the RISC-V core.
- Takes a raw 32-bit instruction word plus a format select and produces the XLEN-wide immediate for I, S, B, U, J and CSR-zimm formats.
- Output is registered behind a 2-entry valid/ready buffer with a sideband tag, so it sits between decode and execute and absorbs one cycle of execute stall without losing data.

Parameters:
- XLEN, 32, datapath/immediate width; legal values 32 or 64.
- TAG_W, 5, width of the sideband tag carried alongside each immediate (e.g. rd index).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream presents instr/imm_src/in_tag.
- in_ready  output  1  block can accept an entry this cycle.
- instr  input  32  raw instruction word.
- imm_src  input  3  format select: 0=I, 1=S, 2=B, 3=U, 4=J, 5=Z (CSR zimm), 6/7 illegal.
- in_tag  input  TAG_W  sideband passed through unchanged.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  downstream consumes head entry.
- imm_out  output  XLEN  extended immediate of head entry.
- out_tag  output  TAG_W  tag of head entry.
- illegal  output  1  head entry had imm_src 6 or 7.

Behaviour:
- Transfers: push when in_valid&&in_ready at a rising edge; pop when out_valid&&out_ready.
- Extension is computed combinationally from instr at push and stored in the buffer entry.
- Extension rules (sext = replicate MSB to XLEN):
  - I: sext(instr[31:20]).
  - S: sext({instr[31:25],instr[11:7]}).
  - B: sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}).
  - U: sext({instr[31:12],12'b0}); identity for XLEN=32, sign-extended from bit 31 for XLEN=64.
  - J: sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}).
  - Z: zero-extend instr[19:15].
  - 6/7: imm 0 and illegal=1 for that entry. An illegal entry is not dropped; it flows through in order.
- Buffer: 2 entries, FIFO order, 2-bit occupancy count 0..2.
  - in_ready = (count!=2) && !rst.
  - out_valid = (count!=0).
  - imm_out/out_tag/illegal always reflect the head entry.
- Latency: an entry pushed at edge N is visible on outputs from edge N (after it) onward, i.e. out_valid the cycle after acceptance. There is no combinational path from in_* to out_*.
- Throughput: 1 entry/cycle sustained when out_ready=1.
- Simultaneous push and pop:
  - count=1: count stays 1, head advances to the new entry.
  - count=2: push impossible (in_ready=0); pop only.
  - count=0: push only (no pop possible).
- Full: count=2 with out_ready=0 holds both entries and all outputs stable; upstream must hold its inputs while in_ready=0.
- Output stability: while out_valid=1 and out_ready=0, imm_out/out_tag/illegal must not change.
- Reset (synchronous, any cycle including mid-transfer or full):
  - Next edge sets count=0, out_valid=0, imm_out=0, out_tag=0, illegal=0.
  - A push or pop asserted in the same cycle as rst is ignored.
  - in_ready is 0 while rst is high and 1 the first cycle after.
- Out-of-range parameters (XLEN not 32/64) are a compile-time error via a generate-time check.

Test Plan:
1. I-type addi x1,x0,-1: instr=32'hFFF00093, imm_src=0, in_valid one cycle, out_ready=1 -> next cycle out_valid=1, imm_out=32'hFFFFFFFF, illegal=0.
2. Format sweep back-to-back, one per cycle:
   - U: 32'h123452B7 (src 3) -> 32'h12345000.
   - S: 32'hFE512E23 (src 1) -> 32'hFFFFFFFC.
   - J: 32'hFFDFF06F (src 4) -> 32'hFFFFFFFC.
   - Z: 32'h000FD073 (src 5) -> 32'h0000001F.
   - Expect 4 consecutive out_valid cycles in order, tags preserved.
3. Backpressure: out_ready=0, offer tags 1,2,3 -> in_ready drops after 2 accepts, tag 3 held upstream. Raise out_ready -> outputs tags 1,2,3 in order, none lost or duplicated.
4. Illegal: imm_src=7, instr=32'hFFFFFFFF, tag=9 -> imm_out=0, illegal=1, out_tag=9; the following legal entry shows illegal=0.
5. Reset mid-operation: buffer full (count=2) with out_ready=0, pulse rst one cycle -> next cycle out_valid=0, imm_out=0, in_ready=1. The first push afterwards appears one cycle later.
6. XLEN=64 build: U-type instr=32'h800000B7 -> imm_out=64'hFFFFFFFF80000000; Z-type still zero-extends to 64 bits.

Source files
------------

// File: rtl/imm_extend_pipe_if.sv
// imm_extend_pipe_if: request/response bundle for the immediate pipe.
// master drives instr/imm_src/in_tag/in_valid and out_ready; slave is the pipe.
interface imm_extend_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instr;
    logic [2:0]       imm_src;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  imm_out;
    logic [TAG_W-1:0] out_tag;
    logic             illegal;

    modport master (
        output in_valid, instr, imm_src, in_tag, out_ready,
        input  in_ready, out_valid, imm_out, out_tag, illegal
    );

    modport slave (
        input  in_valid, instr, imm_src, in_tag, out_ready,
        output in_ready, out_valid, imm_out, out_tag, illegal
    );
endinterface

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: I/S/B/U/J/Z immediate generator behind a 2-entry FIFO.
// Ports: clk, rst (sync, active-high), bus (slave: in_* push side, out_* pop side).
module imm_extend_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input logic              clk,
    input logic              rst,
    imm_extend_pipe_if.slave bus
);
    localparam logic [2:0] SRC_I = 3'd0;
    localparam logic [2:0] SRC_S = 3'd1;
    localparam logic [2:0] SRC_B = 3'd2;
    localparam logic [2:0] SRC_U = 3'd3;
    localparam logic [2:0] SRC_J = 3'd4;
    localparam logic [2:0] SRC_Z = 3'd5;

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("imm_extend_pipe: XLEN must be 32 or 64");
        end
    endgenerate

    logic [31:0]        ins_w;
    logic signed [31:0] s32_w;
    logic               ill_w;
    logic [XLEN-1:0]    imm_w;
    logic               unused_opc_w;

    assign ins_w        = bus.instr;
    assign unused_opc_w = ^ins_w[6:0];

    // Every format fits a signed 32-bit value; widening to XLEN is then
    // a plain sign extension (Z has a zero MSB so it zero-extends).
    always_comb begin
        s32_w = '0;
        ill_w = 1'b0;
        case (bus.imm_src)
            SRC_I: s32_w = {{20{ins_w[31]}}, ins_w[31:20]};
            SRC_S: s32_w = {{20{ins_w[31]}}, ins_w[31:25], ins_w[11:7]};
            SRC_B: s32_w = {{19{ins_w[31]}}, ins_w[31], ins_w[7],
                            ins_w[30:25], ins_w[11:8], 1'b0};
            SRC_U: s32_w = {ins_w[31:12], 12'b0};
            SRC_J: s32_w = {{11{ins_w[31]}}, ins_w[31], ins_w[19:12],
                            ins_w[20], ins_w[30:21], 1'b0};
            SRC_Z: s32_w = {27'b0, ins_w[19:15]};
            default: ill_w = 1'b1;
        endcase
    end

    assign imm_w = XLEN'(s32_w);

    logic [XLEN-1:0]  imm_q [2];
    logic [TAG_W-1:0] tag_q [2];
    logic [1:0]       ill_q;
    logic [1:0]       cnt_q, cnt_d;
    logic             rd_q, rd_d;
    logic             wr_q, wr_d;
    logic             push_w, pop_w;

    assign bus.in_ready  = (cnt_q != 2'd2) && !rst;
    assign bus.out_valid = (cnt_q != 2'd0);
    assign bus.imm_out   = imm_q[rd_q];
    assign bus.out_tag   = tag_q[rd_q];
    assign bus.illegal   = ill_q[rd_q];

    assign push_w = bus.in_valid && bus.in_ready;
    assign pop_w  = bus.out_valid && bus.out_ready;

    always_comb begin
        cnt_d = cnt_q;
        rd_d  = rd_q;
        wr_d  = wr_q;
        if (push_w) wr_d = ~wr_q;
        if (pop_w)  rd_d = ~rd_q;
        case ({push_w, pop_w})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Entries are cleared on reset so the empty head reads as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            imm_q[0] <= '0;
            imm_q[1] <= '0;
            tag_q[0] <= '0;
            tag_q[1] <= '0;
            ill_q    <= '0;
        end else begin
            cnt_q <= cnt_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            if (push_w) begin
                imm_q[wr_q] <= imm_w;
                tag_q[wr_q] <= bus.in_tag;
                ill_q[wr_q] <= ill_w;
            end
        end
    end
endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe: scoreboard bench for imm_extend_pipe (XLEN 32 and 64).
// Random and directed pushes; monitor pops expected entries on each output transfer.
module tb_imm_extend_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    imm_extend_pipe_if #(.XLEN(32), .TAG_W(5)) bus ();
    imm_extend_pipe_if #(.XLEN(64), .TAG_W(5)) bus64 ();

    imm_extend_pipe #(.XLEN(32), .TAG_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    imm_extend_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
        .clk (clk),
        .rst (rst),
        .bus (bus64)
    );

    typedef struct packed {
        logic [31:0] imm;
        logic [4:0]  tag;
        logic        ill;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Reference: immediate as a signed integer built from field weights.
    function automatic logic [63:0] ref_imm(input logic [31:0] i,
                                            input logic [2:0] src);
        longint v;
        case (src)
            3'd0: v = longint'($signed(i)) >>> 20;
            3'd1: v = (longint'($signed(i)) >>> 25) * 32
                      + longint'(i[11:7]);
            3'd2: v = (i[31] ? -64'sd4096 : 64'sd0)
                      + longint'(i[7]) * 2048
                      + longint'(i[30:25]) * 32
                      + longint'(i[11:8]) * 2;
            3'd3: v = longint'($signed(i & 32'hFFFF_F000));
            3'd4: v = (i[31] ? -64'sd1048576 : 64'sd0)
                      + longint'(i[19:12]) * 4096
                      + longint'(i[20]) * 2048
                      + longint'(i[30:21]) * 2;
            3'd5: v = longint'(i[19:15]);
            default: v = 0;
        endcase
        return v;
    endfunction

    // Caller is at posedge+1; returns at posedge+1 just after acceptance.
    task automatic send_exp(input logic [31:0] i, input logic [2:0] src,
                            input logic [4:0] tag, input exp_t e);
        bit ok = 0;
        bus.in_valid = 1'b1;
        bus.instr    = i;
        bus.imm_src  = src;
        bus.in_tag   = tag;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                exp_q.push_back(e);
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: tag %0d never accepted", tag);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send(input logic [31:0] i, input logic [2:0] src,
                        input logic [4:0] tag);
        exp_t e;
        logic [63:0] r;
        r     = ref_imm(i, src);
        e.imm = r[31:0];
        e.tag = tag;
        e.ill = (src >= 3'd6);
        send_exp(i, src, tag, e);
    endtask

    task automatic drain();
        for (int k = 0; k < 200; k++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d entries left want 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: pop-and-compare on every output transfer, plus hold check.
    bit   stall_q = 0;
    exp_t held_q;
    always @(negedge clk) begin
        if (rst) begin
            stall_q = 0;
        end else begin
            if (stall_q && bus.out_valid)
                chk("hold", {bus.imm_out, bus.out_tag, bus.illegal}, held_q);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL pop: tag %0d got, want none",
                             bus.out_tag);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("pop", {bus.imm_out, bus.out_tag, bus.illegal}, e);
                end
            end
            stall_q = bus.out_valid && !bus.out_ready;
            held_q  = {bus.imm_out, bus.out_tag, bus.illegal};
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    bit done = 0;

    initial begin
        bus.in_valid    = 0;
        bus.instr       = '0;
        bus.imm_src     = '0;
        bus.in_tag      = '0;
        bus.out_ready   = 0;
        bus64.in_valid  = 0;
        bus64.instr     = '0;
        bus64.imm_src   = '0;
        bus64.in_tag    = '0;
        bus64.out_ready = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_imm", bus.imm_out, 0);
        @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        chk("post_rst_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;

        // addi x1,x0,-1
        bus.out_ready = 1;
        send_exp(32'hFFF00093, 3'd0, 5'd1, '{32'hFFFFFFFF, 5'd1, 1'b0});
        @(negedge clk);
        chk("lat_out_valid", bus.out_valid, 1);
        @(posedge clk);
        #1;

        // format sweep, back-to-back
        send_exp(32'h123452B7, 3'd3, 5'd2, '{32'h12345000, 5'd2, 1'b0});
        send_exp(32'hFE512E23, 3'd1, 5'd3, '{32'hFFFFFFFC, 5'd3, 1'b0});
        send_exp(32'hFFDFF06F, 3'd4, 5'd4, '{32'hFFFFFFFC, 5'd4, 1'b0});
        send_exp(32'h000FD073, 3'd5, 5'd5, '{32'h0000001F, 5'd5, 1'b0});
        drain();

        // backpressure: third entry must wait upstream
        bus.out_ready = 0;
        fork
            begin
                send(32'h00A00513, 3'd0, 5'd1);
                send(32'h00B00593, 3'd0, 5'd2);
                send(32'h00C00613, 3'd0, 5'd3);
            end
            begin
                repeat (5) @(negedge clk);
                chk("full_in_ready", bus.in_ready, 0);
                chk("full_out_valid", bus.out_valid, 1);
                @(posedge clk);
                #1;
                bus.out_ready = 1;
            end
        join
        drain();

        // illegal entry flows through, next legal one is clean
        send_exp(32'hFFFFFFFF, 3'd7, 5'd9, '{32'h0, 5'd9, 1'b1});
        send_exp(32'h00000063 | 32'h80000000, 3'd2, 5'd10,
                 '{32'hFFFFF000, 5'd10, 1'b0});
        drain();

        // random traffic with random backpressure
        fork
            begin
                for (int n = 0; n < 300; n++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send($urandom(), 3'($urandom_range(0, 7)),
                         5'($urandom()));
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        bus.out_ready = 1;
        drain();

        // reset while full
        bus.out_ready = 0;
        send(32'h7FF00093, 3'd0, 5'd21);
        send(32'h80000037, 3'd3, 5'd22);
        rst = 1;
        @(negedge clk);
        chk("rst_full_in_ready", bus.in_ready, 0);
        @(posedge clk);
        #1;
        rst = 0;
        exp_q.delete();
        @(negedge clk);
        chk("rst_full_out_valid", bus.out_valid, 0);
        chk("rst_full_imm", bus.imm_out, 0);
        chk("rst_full_tag", bus.out_tag, 0);
        chk("rst_full_illegal", bus.illegal, 0);
        chk("rst_full_in_ready_after", bus.in_ready, 1);
        @(posedge clk);
        #1;
        bus.out_ready = 1;
        send(32'h02A00093, 3'd0, 5'd23);
        @(negedge clk);
        chk("rst_push_latency", bus.out_valid, 1);
        @(posedge clk);
        #1;
        drain();

        // XLEN=64 instance
        bus64.out_ready = 1;
        bus64.in_valid  = 1;
        bus64.instr     = 32'h800000B7;
        bus64.imm_src   = 3'd3;
        bus64.in_tag    = 5'd4;
        @(negedge clk);
        chk("x64_in_ready", bus64.in_ready, 1);
        @(posedge clk);
        #1;
        bus64.instr   = 32'h000FD073;
        bus64.imm_src = 3'd5;
        bus64.in_tag  = 5'd6;
        @(negedge clk);
        chk("x64_u_valid", bus64.out_valid, 1);
        chk("x64_u_imm", bus64.imm_out, 64'hFFFFFFFF80000000);
        chk("x64_u_tag", bus64.out_tag, 4);
        @(posedge clk);
        #1;
        bus64.instr   = 32'hFFF00093;
        bus64.imm_src = 3'd0;
        bus64.in_tag  = 5'd7;
        @(negedge clk);
        chk("x64_z_imm", bus64.imm_out, 64'h1F);
        @(posedge clk);
        #1;
        bus64.in_valid = 0;
        @(negedge clk);
        chk("x64_i_imm", bus64.imm_out, ref_imm(32'hFFF00093, 3'd0));
        chk("x64_i_tag", bus64.out_tag, 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
